unidade_controle_multiciclo: RTL and testbench
==============================================

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 Parameter OPCODE_W, default 5: opcode width.
REQ-002 Parameter ULA_W, default 4: ulaControle width.
REQ-003 Parameter PC_W, default 3: pcControle width.
REQ-004 Parameter IN_TIMEOUT, default 0: input-wait cycle limit; 0 means wait forever.
REQ-005 clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  reset is synchronous and active-high.
REQ-007 opcode  in  OPCODE_W  opcode field of the instruction word on the instruction bus.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 entradaValida  in  1  switch input confirmed by the user.
REQ-010 saidaAck  in  1  display accepted the output value.
REQ-011 instrLoad  out  1  load instruction register.
REQ-012 pcEscrita  out  1  update PC this cycle.
REQ-013 pcControle  out  PC_W  PC source: 000 PC+1, 001 jump, 010 branch, 011 register.
REQ-014 regEscrita, memEscrita, selecionaULA, selecionaRegDado, selecionaLoadImediato  out  1 each  datapath strobes and selects.
REQ-015 ulaControle  out  ULA_W  ALU operation.
REQ-016 entradaPronta  out  1  waiting for switch input.
REQ-017 saidaValida  out  1  output value is valid.
REQ-018 parado  out  1  processor halted.
REQ-019 erroTimeout  out  1  sticky flag: input wait expired.
REQ-020 estado  out  3  current FSM state, for debug.

Function
REQ-021 States: BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, ESPERA_ENTRADA=5, ESPERA_SAIDA=6, PARADO=7.
REQ-022 BUSCA: instrLoad=1; opcode is latched into opReg at this edge; next state DECODIFICA.
REQ-023 DECODIFICA: no strobes; next state is one of the following.
- opcode 18 -> PARADO
- opcode 19 -> ESPERA_ENTRADA
- opcode 20 -> ESPERA_SAIDA
- all other opcodes -> EXECUTA
REQ-024 ulaControle is decoded from opReg in every state.
- 1/22 -> 0; 3/4 -> 1; 5/6 -> 2; 7 -> 3; 9 -> 4; 10 -> 5; 11 -> 6; 14 -> 7; 28 -> 8; 29 -> 9; 30 -> 10; 31 -> 11; 2 -> 12; 8 -> 13
- 12/13 -> 1
- any other opcode -> all ones
REQ-025 selecionaULA=1 for opcodes 4, 6, 9, 10, 11, 12, 13, 22, 23, 24.
REQ-026 EXECUTA, ALU ops (1-11, 14, 22, 28-31): next state ESCRITA.
REQ-027 EXECUTA, loads/stores (15, 23, 24, 26): next state MEMORIA.
REQ-028 EXECUTA, opcode 25: next state ESCRITA with selecionaLoadImediato=1.
REQ-029 EXECUTA, control flow: pcEscrita=1, next state BUSCA.
- j (16): pcControle=001
- jr (27): pcControle=011
- beq (12): pcControle=010 when zero is 1, else 000
- bne (13): pcControle=010 when zero is 0, else 000
- zero is sampled in this cycle only.
REQ-030 EXECUTA, undefined opcode: no-op; pcEscrita=1, pcControle=000, next state BUSCA.
REQ-031 MEMORIA, stores (15, 24): memEscrita=1 for exactly one cycle, pcEscrita=1, next state BUSCA.
REQ-032 MEMORIA, loads (23, 26): selecionaRegDado=1, next state ESCRITA.
REQ-033 ESCRITA: regEscrita=1 for exactly one cycle, pcEscrita=1, pcControle=000; selecionaRegDado and selecionaLoadImediato are held from the prior state; next state BUSCA.
REQ-034 ESPERA_ENTRADA: entradaPronta=1.
- entradaValida=1 -> ESCRITA.
- IN_TIMEOUT>0 and counter reaches IN_TIMEOUT -> set erroTimeout, pcEscrita=1, next state BUSCA, no register write.
- The wait counter clears on entry to this state.
REQ-035 ESPERA_SAIDA: saidaValida=1 until a cycle with saidaAck=1; that cycle has pcEscrita=1 and next state BUSCA.
REQ-036 A saidaAck that arrives in the same cycle saidaValida first rises is accepted.
REQ-037 PARADO: parado=1, all strobes 0; state held until reset.
REQ-038 In every state, any strobe not listed for it is 0.
REQ-039 Instruction latencies in cycles:
- ALU ops and li: 4
- loads: 5
- stores: 4
- branches and jumps: 3
- undefined opcode: 3
- in: 3 + wait cycles
- out: 3 + wait cycles

Reset
REQ-040 While reset is 1 at a clock edge: state=BUSCA, opReg=0, wait counter=0, erroTimeout=0.
REQ-041 Reset mid-instruction aborts the instruction; no strobe is asserted in the cycle after reset.

Structure
REQ-042 A shared package holds the state encodings, opcode constants, pcControle codes and ulaControle codes.
REQ-043 The opcode-to-ulaControle/selecionaULA decoder is a combinational sub-module named decodificador_ula.

Verification
REQ-044 add (1) after reset: instrLoad in cycle 0, regEscrita=1 and ulaControle=0 in cycle 3, back in BUSCA in cycle 4.
REQ-045 beq (12) with zero=1: pcEscrita=1 and pcControle=010 in EXECUTA. bne (13) with zero=1: pcControle=000.
REQ-046 lw (23): memEscrita=0 throughout; regEscrita=1 with selecionaRegDado=1 in cycle 4. sw (24): memEscrita=1 in cycle 3 only.
REQ-047 in (19) with IN_TIMEOUT=8, entradaValida held low: erroTimeout=1 after 8 cycles in ESPERA_ENTRADA, then BUSCA. Repeat with entradaValida at wait cycle 2: regEscrita pulses once.
REQ-048 out (20) with saidaAck delayed 5 cycles: saidaValida high for 6 cycles.
REQ-049 halt (18) enters PARADO and stays there 20 cycles; reset asserted in EXECUTA of an addi returns to BUSCA with no regEscrita.

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encodings,
// opcode values, PC source codes and ALU operation codes.
package unidade_controle_multiciclo_pkg;

   typedef enum logic [2:0] {
      BUSCA          = 3'd0,
      DECODIFICA     = 3'd1,
      EXECUTA        = 3'd2,
      MEMORIA        = 3'd3,
      ESCRITA        = 3'd4,
      ESPERA_ENTRADA = 3'd5,
      ESPERA_SAIDA   = 3'd6,
      PARADO         = 3'd7
   } estado_t;

   // Opcodes with dedicated handling in the sequencer
   localparam int OP_BEQ  = 12;
   localparam int OP_BNE  = 13;
   localparam int OP_J    = 16;
   localparam int OP_HALT = 18;
   localparam int OP_IN   = 19;
   localparam int OP_OUT  = 20;
   localparam int OP_LI   = 25;
   localparam int OP_JR   = 27;

   // PC source selection
   localparam int PC_MAIS1  = 0;
   localparam int PC_JUMP   = 1;
   localparam int PC_BRANCH = 2;
   localparam int PC_REG    = 3;

   // ALU operation codes, named by their numeric value
   localparam int ULA_COD_0  = 0;
   localparam int ULA_COD_1  = 1;
   localparam int ULA_COD_2  = 2;
   localparam int ULA_COD_3  = 3;
   localparam int ULA_COD_4  = 4;
   localparam int ULA_COD_5  = 5;
   localparam int ULA_COD_6  = 6;
   localparam int ULA_COD_7  = 7;
   localparam int ULA_COD_8  = 8;
   localparam int ULA_COD_9  = 9;
   localparam int ULA_COD_10 = 10;
   localparam int ULA_COD_11 = 11;
   localparam int ULA_COD_12 = 12;
   localparam int ULA_COD_13 = 13;

   function automatic logic eh_op_ula(input int op);
      return (op >= 1 && op <= 11) || op == 14 || op == 22 || (op >= 28 && op <= 31);
   endfunction

   function automatic logic eh_load(input int op);
      return op == 23 || op == 26;
   endfunction

   function automatic logic eh_store(input int op);
      return op == 15 || op == 24;
   endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador_ula.sv
// Combinational opcode -> ALU operation / ALU operand select decoder.
module decodificador_ula
   import unidade_controle_multiciclo_pkg::*;
#(
   parameter int OPCODE_W = 5,
   parameter int ULA_W    = 4
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic [ULA_W-1:0]    ula_controle_o,
   output logic                seleciona_ula_o
);

   int op;

   // Map the latched opcode to the ALU operation and operand-B select
   always_comb begin
      op              = int'(opcode_i);
      ula_controle_o  = '1;
      seleciona_ula_o = 1'b0;
      case (op)
         1, 22:   ula_controle_o = ULA_W'(ULA_COD_0);
         3, 4:    ula_controle_o = ULA_W'(ULA_COD_1);
         5, 6:    ula_controle_o = ULA_W'(ULA_COD_2);
         7:       ula_controle_o = ULA_W'(ULA_COD_3);
         9:       ula_controle_o = ULA_W'(ULA_COD_4);
         10:      ula_controle_o = ULA_W'(ULA_COD_5);
         11:      ula_controle_o = ULA_W'(ULA_COD_6);
         14:      ula_controle_o = ULA_W'(ULA_COD_7);
         28:      ula_controle_o = ULA_W'(ULA_COD_8);
         29:      ula_controle_o = ULA_W'(ULA_COD_9);
         30:      ula_controle_o = ULA_W'(ULA_COD_10);
         31:      ula_controle_o = ULA_W'(ULA_COD_11);
         2:       ula_controle_o = ULA_W'(ULA_COD_12);
         8:       ula_controle_o = ULA_W'(ULA_COD_13);
         // branches compare by subtraction
         12, 13:  ula_controle_o = ULA_W'(ULA_COD_1);
         default: ula_controle_o = '1;
      endcase
      case (op)
         4, 6, 9, 10, 11, 12, 13, 22, 23, 24: seleciona_ula_o = 1'b1;
         default:                              seleciona_ula_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle processor control unit.
//
//  state          | meaning
//  BUSCA          | fetch: load instruction register, latch opcode
//  DECODIFICA     | decode: dispatch halt / in / out / execute
//  EXECUTA        | ALU op, address calc, branch/jump resolution
//  MEMORIA        | memory access (store completes here)
//  ESCRITA        | register write-back, PC+1
//  ESPERA_ENTRADA | waiting for user switch input (optional timeout)
//  ESPERA_SAIDA   | output valid, waiting for display ack
//  PARADO         | halted until reset
module unidade_controle_multiciclo
   import unidade_controle_multiciclo_pkg::*;
#(
   parameter int OPCODE_W   = 5,
   parameter int ULA_W      = 4,
   parameter int PC_W       = 3,
   parameter int IN_TIMEOUT = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                entradaValida,
   input  logic                saidaAck,
   output logic                instrLoad,
   output logic                pcEscrita,
   output logic [PC_W-1:0]     pcControle,
   output logic                regEscrita,
   output logic                memEscrita,
   output logic                selecionaULA,
   output logic                selecionaRegDado,
   output logic                selecionaLoadImediato,
   output logic [ULA_W-1:0]    ulaControle,
   output logic                entradaPronta,
   output logic                saidaValida,
   output logic                parado,
   output logic                erroTimeout,
   output logic [2:0]          estado
);

   localparam int CNT_W = (IN_TIMEOUT > 1) ? $clog2(IN_TIMEOUT) : 1;

   estado_t             estado_q, estado_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                erro_q, erro_d;
   int                  op;

   decodificador_ula #(
      .OPCODE_W (OPCODE_W),
      .ULA_W    (ULA_W)
   ) u_decodificador_ula (
      .opcode_i        (op_q),
      .ula_controle_o  (ulaControle),
      .seleciona_ula_o (selecionaULA)
   );

   // State, opcode latch, input-wait counter and sticky timeout flag
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= BUSCA;
         op_q     <= '0;
         cnt_q    <= '0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         erro_q   <= erro_d;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      op                    = int'(op_q);
      estado_d              = estado_q;
      op_d                  = op_q;
      cnt_d                 = cnt_q;
      erro_d                = erro_q;
      instrLoad             = 1'b0;
      pcEscrita             = 1'b0;
      pcControle            = PC_W'(PC_MAIS1);
      regEscrita            = 1'b0;
      memEscrita            = 1'b0;
      selecionaRegDado      = 1'b0;
      selecionaLoadImediato = 1'b0;
      entradaPronta         = 1'b0;
      saidaValida           = 1'b0;
      parado                = 1'b0;
      case (estado_q)
         BUSCA: begin
            instrLoad = 1'b1;
            op_d      = opcode;
            estado_d  = DECODIFICA;
         end
         DECODIFICA: begin
            case (op)
               OP_HALT: estado_d = PARADO;
               OP_IN: begin
                  estado_d = ESPERA_ENTRADA;
                  cnt_d    = '0;
               end
               OP_OUT:  estado_d = ESPERA_SAIDA;
               default: estado_d = EXECUTA;
            endcase
         end
         EXECUTA: begin
            if (eh_op_ula(op)) begin
               estado_d = ESCRITA;
            end else if (eh_load(op) || eh_store(op)) begin
               estado_d = MEMORIA;
            end else if (op == OP_LI) begin
               selecionaLoadImediato = 1'b1;
               estado_d              = ESCRITA;
            end else begin
               // control flow and undefined opcodes both finish here
               pcEscrita = 1'b1;
               estado_d  = BUSCA;
               case (op)
                  OP_J:    pcControle = PC_W'(PC_JUMP);
                  OP_JR:   pcControle = PC_W'(PC_REG);
                  OP_BEQ:  if (zero)  pcControle = PC_W'(PC_BRANCH);
                  OP_BNE:  if (!zero) pcControle = PC_W'(PC_BRANCH);
                  default: pcControle = PC_W'(PC_MAIS1);
               endcase
            end
         end
         MEMORIA: begin
            if (eh_store(op)) begin
               memEscrita = 1'b1;
               pcEscrita  = 1'b1;
               estado_d   = BUSCA;
            end else begin
               selecionaRegDado = 1'b1;
               estado_d         = ESCRITA;
            end
         end
         ESCRITA: begin
            // data selects are re-derived from the latched opcode so they
            // stay stable across the write-back cycle
            regEscrita            = 1'b1;
            pcEscrita             = 1'b1;
            selecionaRegDado      = eh_load(op);
            selecionaLoadImediato = (op == OP_LI);
            estado_d              = BUSCA;
         end
         ESPERA_ENTRADA: begin
            entradaPronta = 1'b1;
            if (entradaValida) begin
               estado_d = ESCRITA;
            end else if (IN_TIMEOUT > 0 && int'(cnt_q) == IN_TIMEOUT - 1) begin
               erro_d    = 1'b1;
               pcEscrita = 1'b1;
               estado_d  = BUSCA;
            end else if (IN_TIMEOUT > 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ESPERA_SAIDA: begin
            saidaValida = 1'b1;
            if (saidaAck) begin
               pcEscrita = 1'b1;
               estado_d  = BUSCA;
            end
         end
         PARADO: begin
            parado = 1'b1;
         end
         default: estado_d = BUSCA;
      endcase
   end

   assign erroTimeout = erro_q;
   assign estado      = estado_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit (IN_TIMEOUT = 8).
module tb_unidade_controle_multiciclo;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] opcode;
   logic       zero;
   logic       entradaValida;
   logic       saidaAck;
   logic       instrLoad, pcEscrita, regEscrita, memEscrita;
   logic [2:0] pcControle;
   logic       selecionaULA, selecionaRegDado, selecionaLoadImediato;
   logic [3:0] ulaControle;
   logic       entradaPronta, saidaValida, parado, erroTimeout;
   logic [2:0] estado;

   int checks   = 0;
   int failures = 0;

   unidade_controle_multiciclo #(
      .OPCODE_W   (5),
      .ULA_W      (4),
      .PC_W       (3),
      .IN_TIMEOUT (8)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .opcode                (opcode),
      .zero                  (zero),
      .entradaValida         (entradaValida),
      .saidaAck              (saidaAck),
      .instrLoad             (instrLoad),
      .pcEscrita             (pcEscrita),
      .pcControle            (pcControle),
      .regEscrita            (regEscrita),
      .memEscrita            (memEscrita),
      .selecionaULA          (selecionaULA),
      .selecionaRegDado      (selecionaRegDado),
      .selecionaLoadImediato (selecionaLoadImediato),
      .ulaControle           (ulaControle),
      .entradaPronta         (entradaPronta),
      .saidaValida           (saidaValida),
      .parado                (parado),
      .erroTimeout           (erroTimeout),
      .estado                (estado)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int wr;
      int vcount;
      int bad;

      reset = 1'b1; opcode = 5'd0; zero = 1'b0; entradaValida = 1'b0; saidaAck = 1'b0;
      tick; tick;
      reset = 1'b0;
      #1;
      chk("rst_estado", estado, 0);
      chk("rst_erro", erroTimeout, 0);
      chk("rst_ula", ulaControle, 4'hF);
      chk("rst_regw", regEscrita, 0);

      // add: 4 cycles
      opcode = 5'd1; #1;
      chk("add_c0_instrLoad", instrLoad, 1);
      tick; chk("add_c1_estado", estado, 1); chk("add_c1_instrLoad", instrLoad, 0);
      tick; chk("add_c2_estado", estado, 2); chk("add_c2_regw", regEscrita, 0);
      tick; chk("add_c3_regw", regEscrita, 1); chk("add_c3_ula", ulaControle, 0);
      chk("add_c3_pcw", pcEscrita, 1); chk("add_c3_estado", estado, 4);
      tick; chk("add_c4_estado", estado, 0); chk("add_c4_regw", regEscrita, 0);

      // beq zero=1
      opcode = 5'd12; tick; tick;
      zero = 1'b1; #1;
      chk("beq_estado", estado, 2); chk("beq_pcw", pcEscrita, 1);
      chk("beq_pcc", pcControle, 3'b010); chk("beq_ula", ulaControle, 1);
      chk("beq_selula", selecionaULA, 1);
      tick; chk("beq_back", estado, 0);

      // bne zero=1 then zero=0 in the same EXECUTA cycle
      opcode = 5'd13; tick; tick;
      zero = 1'b1; #1;
      chk("bne_z1_pcc", pcControle, 3'b000); chk("bne_z1_pcw", pcEscrita, 1);
      zero = 1'b0; #1;
      chk("bne_z0_pcc", pcControle, 3'b010);
      tick; chk("bne_back", estado, 0);

      // j
      opcode = 5'd16; tick; tick;
      chk("j_pcc", pcControle, 3'b001);
      tick; chk("j_back", estado, 0);

      // undefined opcode 17
      opcode = 5'd17; tick; tick;
      chk("undef_pcw", pcEscrita, 1); chk("undef_pcc", pcControle, 0);
      chk("undef_ula", ulaControle, 4'hF);
      tick; chk("undef_back", estado, 0);

      // lw: 5 cycles
      opcode = 5'd23; bad = 0;
      if (memEscrita !== 1'b0) bad++;
      tick; if (memEscrita !== 1'b0) bad++;
      tick; if (memEscrita !== 1'b0) bad++;
      chk("lw_c2_selula", selecionaULA, 1);
      tick; if (memEscrita !== 1'b0) bad++;
      chk("lw_c3_estado", estado, 3); chk("lw_c3_regdado", selecionaRegDado, 1);
      tick; if (memEscrita !== 1'b0) bad++;
      chk("lw_c4_regw", regEscrita, 1); chk("lw_c4_regdado", selecionaRegDado, 1);
      chk("lw_memw_never", bad, 0);
      tick; chk("lw_back", estado, 0);

      // sw: memEscrita only in cycle 3
      opcode = 5'd24; tick; tick;
      chk("sw_c2_memw", memEscrita, 0);
      tick; chk("sw_c3_memw", memEscrita, 1); chk("sw_c3_pcw", pcEscrita, 1);
      chk("sw_c3_regw", regEscrita, 0);
      tick; chk("sw_c4_memw", memEscrita, 0); chk("sw_back", estado, 0);

      // li
      opcode = 5'd25; tick; tick;
      chk("li_c2_sli", selecionaLoadImediato, 1);
      tick; chk("li_c3_regw", regEscrita, 1); chk("li_c3_sli", selecionaLoadImediato, 1);
      tick; chk("li_back", estado, 0);

      // in with timeout (entradaValida low)
      opcode = 5'd19; entradaValida = 1'b0; tick; tick;
      chk("in_to_erro_before", erroTimeout, 0);
      chk("in_to_pronta", entradaPronta, 1);
      n = 0; wr = 0;
      while (estado == 3'd5 && n < 20) begin
         n++;
         if (regEscrita) wr++;
         tick;
      end
      chk("in_to_wait_cycles", n, 8);
      chk("in_to_erro", erroTimeout, 1);
      chk("in_to_estado", estado, 0);
      chk("in_to_no_regw", wr, 0);

      // in with entradaValida at wait cycle 2
      opcode = 5'd19; tick; tick;
      chk("in_ok_w1", estado, 5); chk("in_ok_w1_regw", regEscrita, 0);
      tick; entradaValida = 1'b1; #1;
      chk("in_ok_w2", estado, 5);
      tick; entradaValida = 1'b0; #1;
      chk("in_ok_regw", regEscrita, 1); chk("in_ok_estado", estado, 4);
      tick; chk("in_ok_regw_off", regEscrita, 0); chk("in_ok_back", estado, 0);

      // out with ack delayed 5 cycles
      opcode = 5'd20; tick; tick;
      n = 0; vcount = 0;
      while (estado == 3'd6 && n < 20) begin
         if (n == 5) saidaAck = 1'b1;
         #1;
         if (saidaValida) vcount++;
         n++;
         tick;
      end
      saidaAck = 1'b0; #1;
      chk("out_valid_cycles", vcount, 6);
      chk("out_back", estado, 0);

      // out with ack already high when saidaValida rises
      opcode = 5'd20; tick;
      saidaAck = 1'b1; tick;
      chk("out_imm_valid", saidaValida, 1); chk("out_imm_pcw", pcEscrita, 1);
      tick; saidaAck = 1'b0; #1;
      chk("out_imm_back", estado, 0);

      // halt
      opcode = 5'd18; tick; tick;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (estado !== 3'd7 || parado !== 1'b1 || pcEscrita || regEscrita ||
             memEscrita || instrLoad || saidaValida || entradaPronta) bad++;
         tick;
      end
      chk("halt_held", bad, 0);
      chk("halt_estado", estado, 7);
      reset = 1'b1; tick; reset = 1'b0; #1;
      chk("halt_rst_estado", estado, 0);
      chk("rst_clears_erro", erroTimeout, 0);

      // addi aborted by reset in EXECUTA
      opcode = 5'd22; tick; tick;
      chk("addi_estado", estado, 2); chk("addi_selula", selecionaULA, 1);
      reset = 1'b1; tick; reset = 1'b0; #1;
      chk("addi_rst_estado", estado, 0); chk("addi_rst_regw", regEscrita, 0);
      chk("addi_rst_pcw", pcEscrita, 0); chk("addi_rst_ula", ulaControle, 4'hF);
      opcode = 5'd17;
      tick; chk("addi_after_regw", regEscrita, 0); chk("addi_after_estado", estado, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
